// File: rtl/vblank_update_arbiter_if.sv
// Update-slot handshake between the arbiter and its requesters.
//   req   : level requests, one bit per requester
//   done  : completion strobes; only the current grantee's bit matters
//   grant : one-hot (or zero) grant, registered inside the arbiter
// master = requester side, slave = arbiter side.
interface vblank_update_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;

  modport master (output req, output done, input grant);
  modport slave  (input req, input done, output grant);
endinterface

// File: rtl/vblank_update_arbiter.sv
// Grants the game-logic update slot to one requester at a time, round-robin,
// only while the raster is inside the vertical-blanking update window, so
// paddle/ball/score state never changes mid-scan. Each requester is served
// at most once per frame.
// Ports:
//   clk, rst      : pixel clock, synchronous active-high reset
//   counter_x/_y  : raster position from the sync generator
//   bus (slave)   : req / done in, grant out
//   err_clr       : clears sticky timeout flags
//   window_open   : registered window condition
//   frame_tick    : one-cycle pulse when the window opens
//   overrun       : one-cycle pulse when window close revokes a grant
//   timeout_err   : sticky per-requester timeout flags
//   frame_count   : frames seen, wraps at 0xFFFF
module vblank_update_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIN_START = 480,
  parameter int unsigned WIN_END   = 510,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned TO_W      = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            counter_x,
  input  logic [8:0]            counter_y,
  vblank_update_arbiter_if.slave bus,
  input  logic                  err_clr,
  output logic                  window_open,
  output logic                  frame_tick,
  output logic                  overrun,
  output logic [N_REQ-1:0]      timeout_err,
  output logic [15:0]           frame_count
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ARB, GRANT, GUARD} state_t;

  state_t             state;
  logic [N_REQ-1:0]   grantQ;
  logic [N_REQ-1:0]   served;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   winner;
  logic [TO_W-1:0]    timer;

  logic               winCond;
  logic               tickCond;
  logic [N_REQ-1:0]   eligible;
  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   rrNext;

  // The window is line-granular; X is carried only for interface symmetry.
  logic unusedX;
  assign unusedX = ^counter_x;

  assign bus.grant = grantQ;

  assign winCond  = (counter_y >= 9'(WIN_START)) && (counter_y <= 9'(WIN_END));
  assign tickCond = winCond && !window_open;
  assign eligible = bus.req & ~served;

  function automatic logic [IDX_W-1:0] wrapIdx(input int unsigned base, input int unsigned offs);
    int unsigned s;
    s = base + offs;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Circular first-set search starting at the round-robin pointer.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = wrapIdx(32'(rrPtr), i);
      if (!pickValid && eligible[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  assign rrNext = (pickIdx == IDX_W'(N_REQ - 1)) ? '0 : pickIdx + IDX_W'(1);

  // State, grant and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grantQ      <= '0;
      served      <= '0;
      rrPtr       <= '0;
      winner      <= '0;
      timer       <= '0;
      window_open <= 1'b0;
      frame_tick  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= '0;
      frame_count <= '0;
    end else begin
      window_open <= winCond;
      frame_tick  <= tickCond;
      overrun     <= 1'b0;
      // A timeout set below lands after this clear, so the set wins.
      timeout_err <= timeout_err & ~{N_REQ{err_clr}};

      if (tickCond) begin
        frame_count <= frame_count + 16'd1;
        served      <= '0;
      end

      case (state)
        IDLE: begin
          grantQ <= '0;
          if (tickCond) state <= ARB;
        end

        // GUARD is the zero-grant gap after a grant; it also arbitrates so
        // consecutive grants are separated by exactly one idle cycle.
        ARB, GUARD: begin
          grantQ <= '0;
          if (!winCond) begin
            state <= IDLE;
          end else if (pickValid) begin
            grantQ          <= N_REQ'(1) << pickIdx;
            winner          <= pickIdx;
            served[pickIdx] <= 1'b1;
            rrPtr           <= rrNext;
            timer           <= '0;
            state           <= GRANT;
          end else begin
            state <= ARB;
          end
        end

        // Exit priority: done, then window close, then timeout.
        GRANT: begin
          timer <= timer + TO_W'(1);
          if (bus.done[winner]) begin
            grantQ <= '0;
            state  <= GUARD;
          end else if (!winCond) begin
            grantQ  <= '0;
            overrun <= 1'b1;
            state   <= IDLE;
          end else if (timer == TO_W'(TIMEOUT - 1)) begin
            grantQ              <= '0;
            timeout_err[winner] <= 1'b1;
            state               <= GUARD;
          end
        end

        default: begin
          grantQ <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule
